// File: rtl/uart_byte_transmitter.sv
// Byte-wide UART transmitter: small write FIFO feeding an 8N1 serializer.
// uart_tx is registered; ready is FIFO-not-full, busy covers both FIFO and frame.
module uart_byte_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            tx_q, tx_d;
  logic            push, pop;

  assign ready   = (count_q != COUNT_FULL);
  assign uart_tx = tx_q;
  assign busy    = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    push      = valid && ready && !reset;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          state_d   = START;
          tx_d      = 1'b0;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = BIT_RELOAD;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_cnt_q == '0) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = BIT_RELOAD;
          bit_idx_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt_q == '0) begin
          // Chain straight into the next start bit when bytes are waiting.
          if (count_q != '0) begin
            pop       = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = BIT_RELOAD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_byte_transmitter.md
UART_BYTE_TRANSMITTER -- requirements
Module: uart_byte_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data  input  8  byte to transmit.
REQ-006 SHALL have port valid  input  1  data is presented this cycle.
REQ-007 SHALL have port ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port uart_tx  output  1  serial line toward the core's UART receive input; idle high.
REQ-009 SHALL have port busy  output  1  a frame is in progress or the FIFO holds bytes.

Function
REQ-010 SHALL accept a byte on a rising edge where valid and ready are both high; valid while ready is low SHALL be ignored, with no state change.
REQ-011 SHALL derive ready combinationally as FIFO not full; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-012 SHALL transmit 8N1 frames: one start bit (0), eight data bits LSB first, one stop bit (1), no parity.
REQ-013 SHALL drive uart_tx from a register, with no combinational path from inputs.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP.
- IDLE to START: FIFO not empty; pop the head byte into the shift register and drive uart_tx to 0 on the same edge.
- START to DATA: after CLKS_PER_BIT cycles.
- DATA to STOP: after 8 bits of CLKS_PER_BIT cycles each.
- STOP to START: at the end of the stop bit if the FIFO is not empty, with zero idle cycles between frames.
- STOP to IDLE: at the end of the stop bit otherwise.
REQ-015 SHALL make uart_tx fall exactly one cycle after the accepting edge when a byte is written to an empty FIFO in IDLE.
REQ-016 SHALL hold every bit for exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
REQ-017 SHALL time bits with a bit counter reloaded to CLKS_PER_BIT-1 at each bit start and decremented to 0, plus a 3-bit data-bit index.
REQ-018 SHALL keep FIFO pointers with wrap-around modulo FIFO_DEPTH and full/empty derived from a count of width log2(FIFO_DEPTH)+1.
REQ-019 SHALL transmit FIFO contents in write order, with no loss or duplication across pointer wrap.
REQ-020 SHALL drive busy high when state is not IDLE or the FIFO is not empty.
REQ-021 SHALL NOT let a write during the last cycle of STOP affect the current frame; the next frame starts per REQ-014.

Reset
REQ-022 SHALL, when reset is high at a rising edge, set uart_tx=1, state=IDLE, FIFO empty, ready=1, busy=0, and clear all counters.
REQ-023 SHALL, on reset mid-frame, abort the frame, force uart_tx high on the next cycle, and discard all queued bytes.
REQ-024 SHALL ignore valid in any cycle where reset is high.

Verification
REQ-025 Bench SHALL cover a single byte: CLKS_PER_BIT=4, write 0x55 after reset -> uart_tx 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy falls after 40 cycles.
REQ-026 Bench SHALL cover back-to-back bytes: write 0xA5 then 0x3C on consecutive cycles -> second start bit immediately follows the first stop bit; line idle after 80 cycles; decoded bytes 0xA5, 0x3C.
REQ-027 Bench SHALL cover FIFO full: hold valid high with bytes 0x01..0x06 (FIFO_DEPTH=4) -> 5 bytes accepted, then ready=0 until the first frame ends; all 6 bytes sent in order.
REQ-028 Bench SHALL cover reset mid-frame: assert reset during data bit 3 of 0xF0 with 2 bytes queued -> uart_tx=1 on the next cycle, ready=1, busy=0, and no further frames.
REQ-029 Bench SHALL cover pointer wrap: 12 consecutive bytes 0x00..0x0B paced through the FIFO -> the UART receiver model decodes all 12 in order, with no framing errors.
REQ-030 Bench SHALL cover an ignored write: pulse valid with 0x77 while ready=0 and withdraw it -> 0x77 is never transmitted.
